// File: rtl/axis_pkg.sv
// Shared types and sizing helpers for the AXI-Stream FIFO slice.
package axis_pkg;

    localparam int AXIS_DATA_W = 64;

    typedef struct packed {
        logic                   tlast;
        logic [AXIS_DATA_W-1:0] tdata;
    } axis_beat_t;

    // Occupancy counts 0..depth inclusive, so it needs one more code than a pointer.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_stream_fifo_if.sv
// One AXI-Stream link; the FIFO uses one instance per side.
interface axis_stream_fifo_if #(
    parameter int DATA_W = 64
);

    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        output tready
    );

endinterface

// File: rtl/axis_fifo_ram.sv
// Beat storage: synchronous write, asynchronous read, deliberately not reset.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  axis_beat_t               wr_beat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output axis_beat_t               rd_beat
);

    axis_beat_t mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_beat;
        end
    end

    assign rd_beat = mem[rd_addr];

endmodule

// File: rtl/axis_stream_fifo.sv
// First-word-fall-through FIFO for AXI-Stream beats with occupancy,
// stored-packet count and almost-full reporting.
module axis_stream_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W       = AXIS_DATA_W,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    axis_stream_fifo_if.slave            s_axis,
    axis_stream_fifo_if.master           m_axis,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    output logic [occ_width(DEPTH)-1:0]  pkt_count,
    output logic                         almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    localparam logic [OCC_W-1:0] FULL_LEVEL  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] AFULL_LEVEL = OCC_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] pkt_q, pkt_d;
    logic             s_tready_q, s_tready_d;
    logic             almost_full_q, almost_full_d;

    logic             wr_en;
    logic             rd_en;
    logic             m_tvalid;
    logic             wr_pkt;
    logic             rd_pkt;
    axis_beat_t       wr_beat;
    axis_beat_t       rd_beat;

    axis_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_beat (wr_beat),
        .rd_addr (rd_ptr_q),
        .rd_beat (rd_beat)
    );

    // Handshakes are qualified only by registered state, so there is no input-to-output path.
    always_comb begin
        m_tvalid      = (occ_q != '0);
        wr_en         = s_axis.tvalid && s_tready_q;
        rd_en         = m_tvalid && m_axis.tready;
        wr_pkt        = wr_en && s_axis.tlast;
        rd_pkt        = rd_en && rd_beat.tlast;
        wr_beat.tlast = s_axis.tlast;
        wr_beat.tdata = s_axis.tdata;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        pkt_d    = pkt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        case ({wr_pkt, rd_pkt})
            2'b10:   pkt_d = pkt_q + OCC_W'(1);
            2'b01:   pkt_d = pkt_q - OCC_W'(1);
            default: pkt_d = pkt_q;
        endcase

        // Flags come from next-state occupancy so they line up with the counter.
        s_tready_d    = (occ_d != FULL_LEVEL);
        almost_full_d = (occ_d >= AFULL_LEVEL);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            pkt_q         <= '0;
            s_tready_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            pkt_q         <= pkt_d;
            s_tready_q    <= s_tready_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign s_axis.tready = s_tready_q;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tlast  = m_tvalid ? rd_beat.tlast : 1'b0;
    assign m_axis.tdata  = m_tvalid ? rd_beat.tdata : '0;

    assign occupancy   = occ_q;
    assign pkt_count   = pkt_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed self-checking bench for axis_stream_fifo (DEPTH=16, AFULL_THRESH=14).
module tb_axis_stream_fifo;
    import axis_pkg::*;

    localparam int DEPTH = 16;

    logic       aclk;
    logic       aresetn;
    logic [4:0] occupancy;
    logic [4:0] pkt_count;
    logic       almost_full;

    int checks;
    int errors;

    axis_stream_fifo_if #(.DATA_W(64)) s_if ();
    axis_stream_fifo_if #(.DATA_W(64)) m_if ();

    axis_stream_fifo #(
        .DATA_W       (64),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (DEPTH - 2)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .occupancy   (occupancy),
        .pkt_count   (pkt_count),
        .almost_full (almost_full)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn     = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        tick();
        tick();
        checks++;
        if (s_if.tready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_s_tready got %0b want 0", s_if.tready);
        end
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_m_side got v=%0b l=%0b d=%h want 0/0/0", m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        checks++;
        if (occupancy !== 5'd0 || pkt_count !== 5'd0 || almost_full !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_counts got occ=%0d pkt=%0d af=%0b want 0/0/0", occupancy, pkt_count, almost_full);
        end
        aresetn = 1'b1;
        checks++;
        if (s_if.tready !== 1'b0) begin
            errors++; $display("[TB] FAIL release_before_edge_s_tready got %0b want 0", s_if.tready);
        end
        tick();
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++; $display("[TB] FAIL release_s_tready got %0b want 1", s_if.tready);
        end
        checks++;
        if (m_if.tvalid !== 1'b0 || occupancy !== 5'd0 || pkt_count !== 5'd0) begin
            errors++; $display("[TB] FAIL release_idle got v=%0b occ=%0d pkt=%0d want 0/0/0", m_if.tvalid, occupancy, pkt_count);
        end
    endtask

    task automatic test_single_beat();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 64'hDEAD_BEEF_0123_4567;
        s_if.tlast  = 1'b1;
        m_if.tready = 1'b1;
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL single_no_bypass got m_tvalid=%0b want 0", m_if.tvalid);
        end
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 64'hDEAD_BEEF_0123_4567 || m_if.tlast !== 1'b1) begin
            errors++; $display("[TB] FAIL single_out got v=%0b d=%h l=%0b want 1/deadbeef01234567/1", m_if.tvalid, m_if.tdata, m_if.tlast);
        end
        checks++;
        if (occupancy !== 5'd1 || pkt_count !== 5'd1) begin
            errors++; $display("[TB] FAIL single_counts got occ=%0d pkt=%0d want 1/1", occupancy, pkt_count);
        end
        tick();
        m_if.tready = 1'b0;
        checks++;
        if (m_if.tvalid !== 1'b0 || occupancy !== 5'd0 || pkt_count !== 5'd0 || m_if.tdata !== 64'h0) begin
            errors++; $display("[TB] FAIL single_drained got v=%0b occ=%0d pkt=%0d d=%h want 0/0/0/0", m_if.tvalid, occupancy, pkt_count, m_if.tdata);
        end
    endtask

    task automatic test_fill_full();
        m_if.tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (s_if.tready !== 1'b1) begin
                errors++; $display("[TB] FAIL fill_ready beat %0d got %0b want 1", i, s_if.tready);
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = 64'h100 + 64'(i);
            s_if.tlast  = (i == DEPTH - 1);
            tick();
            checks++;
            if (occupancy !== 5'(i + 1) || almost_full !== ((i + 1) >= 14)) begin
                errors++; $display("[TB] FAIL fill_occ beat %0d got occ=%0d af=%0b want %0d/%0b", i, occupancy, almost_full, i + 1, (i + 1) >= 14);
            end
        end
        s_if.tdata = 64'hBAD;
        s_if.tlast = 1'b0;
        checks++;
        if (s_if.tready !== 1'b0 || pkt_count !== 5'd1 || m_if.tdata !== 64'h100) begin
            errors++; $display("[TB] FAIL full_state got rdy=%0b pkt=%0d d=%h want 0/1/100", s_if.tready, pkt_count, m_if.tdata);
        end
        m_if.tready = 1'b1;
        checks++;
        if (s_if.tready !== 1'b0) begin
            errors++; $display("[TB] FAIL full_read_cycle_ready got %0b want 0", s_if.tready);
        end
        tick();
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b0;
        checks++;
        if (occupancy !== 5'd15 || s_if.tready !== 1'b1 || almost_full !== 1'b1 || m_if.tdata !== 64'h101) begin
            errors++; $display("[TB] FAIL after_pulse got occ=%0d rdy=%0b af=%0b d=%h want 15/1/1/101", occupancy, s_if.tready, almost_full, m_if.tdata);
        end
        m_if.tready = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== 64'h100 + 64'(k) || m_if.tlast !== (k == DEPTH - 1)) begin
                errors++; $display("[TB] FAIL drain beat %0d got v=%0b d=%h l=%0b want 1/%h/%0b", k, m_if.tvalid, m_if.tdata, m_if.tlast, 64'h100 + 64'(k), k == DEPTH - 1);
            end
            tick();
        end
        m_if.tready = 1'b0;
        checks++;
        if (occupancy !== 5'd0 || pkt_count !== 5'd0 || m_if.tvalid !== 1'b0 || almost_full !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_end got occ=%0d pkt=%0d v=%0b af=%0b want 0/0/0/0", occupancy, pkt_count, m_if.tvalid, almost_full);
        end
    endtask

    task automatic test_back_to_back();
        int wi;
        int ri;
        bit rd;
        bit wr;
        wi = 0;
        ri = 0;
        m_if.tready = 1'b1;
        for (int cyc = 0; cyc < 300 && ri < 100; cyc++) begin
            s_if.tvalid = (wi < 100);
            s_if.tdata  = 64'(wi);
            s_if.tlast  = (wi % 5 == 4);
            checks++;
            if (m_if.tvalid !== (wi > ri) || s_if.tready !== 1'b1) begin
                errors++; $display("[TB] FAIL stream_flags cyc %0d got v=%0b rdy=%0b want %0b/1", cyc, m_if.tvalid, s_if.tready, wi > ri);
            end
            if (wi > ri) begin
                checks++;
                if (m_if.tdata !== 64'(ri) || m_if.tlast !== (ri % 5 == 4)) begin
                    errors++; $display("[TB] FAIL stream_data beat %0d got d=%h l=%0b want %h/%0b", ri, m_if.tdata, m_if.tlast, 64'(ri), ri % 5 == 4);
                end
            end
            if (wi > 0 && wi < 100) begin
                checks++;
                if (occupancy !== 5'd1) begin
                    errors++; $display("[TB] FAIL stream_occ cyc %0d got %0d want 1", cyc, occupancy);
                end
            end
            checks++;
            if (pkt_count > 5'd1) begin
                errors++; $display("[TB] FAIL stream_pkt cyc %0d got %0d want <=1", cyc, pkt_count);
            end
            rd = (wi > ri);
            wr = (wi < 100);
            tick();
            if (rd) ri++;
            if (wr) wi++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        checks++;
        if (ri != 100 || occupancy !== 5'd0) begin
            errors++; $display("[TB] FAIL stream_done got beats=%0d occ=%0d want 100/0", ri, occupancy);
        end
    endtask

    task automatic test_backpressure();
        axis_beat_t src[$];
        axis_beat_t exp_q[$];
        axis_beat_t b;
        int         lens[3];
        int         k;
        int         n_last;
        bit         wr;
        bit         rd;
        bit         stalled;
        logic [63:0] held;
        lens = '{1, 7, 20};
        k = 0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < lens[p]; j++) begin
                b.tdata = 64'hA5A5_0000_0000_0000 + 64'(k);
                b.tlast = (j == lens[p] - 1);
                src.push_back(b);
                k++;
            end
        end
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 2000 && (src.size() > 0 || exp_q.size() > 0); cyc++) begin
            n_last = 0;
            foreach (exp_q[i]) if (exp_q[i].tlast) n_last++;
            checks++;
            if (occupancy !== 5'(exp_q.size()) || pkt_count !== 5'(n_last)) begin
                errors++; $display("[TB] FAIL bp_counts cyc %0d got occ=%0d pkt=%0d want %0d/%0d", cyc, occupancy, pkt_count, exp_q.size(), n_last);
            end
            checks++;
            if (m_if.tvalid !== (exp_q.size() != 0) || s_if.tready !== (exp_q.size() != DEPTH)) begin
                errors++; $display("[TB] FAIL bp_flags cyc %0d got v=%0b rdy=%0b want %0b/%0b", cyc, m_if.tvalid, s_if.tready, exp_q.size() != 0, exp_q.size() != DEPTH);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (m_if.tdata !== exp_q[0].tdata || m_if.tlast !== exp_q[0].tlast) begin
                    errors++; $display("[TB] FAIL bp_data cyc %0d got d=%h l=%0b want %h/%0b", cyc, m_if.tdata, m_if.tlast, exp_q[0].tdata, exp_q[0].tlast);
                end
            end
            if (stalled) begin
                checks++;
                if (m_if.tdata !== held) begin
                    errors++; $display("[TB] FAIL bp_hold cyc %0d got %h want %h", cyc, m_if.tdata, held);
                end
            end
            s_if.tvalid = (src.size() > 0) && ($urandom_range(0, 3) != 0);
            s_if.tdata  = (src.size() > 0) ? src[0].tdata : 64'h0;
            s_if.tlast  = (src.size() > 0) ? src[0].tlast : 1'b0;
            m_if.tready = 1'($urandom_range(0, 1));
            wr = s_if.tvalid && (exp_q.size() != DEPTH);
            rd = (exp_q.size() != 0) && m_if.tready;
            stalled = (exp_q.size() != 0) && !m_if.tready;
            held    = (exp_q.size() != 0) ? exp_q[0].tdata : 64'h0;
            tick();
            if (rd) void'(exp_q.pop_front());
            if (wr) exp_q.push_back(src.pop_front());
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        checks++;
        if (src.size() != 0 || exp_q.size() != 0 || occupancy !== 5'd0) begin
            errors++; $display("[TB] FAIL bp_timeout left src=%0d exp=%0d occ=%0d want 0/0/0", src.size(), exp_q.size(), occupancy);
        end
    endtask

    task automatic test_reset_mid_packet();
        m_if.tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 64'hC00 + 64'(i);
            s_if.tlast  = (i == 3);
            tick();
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        checks++;
        if (occupancy !== 5'd9 || pkt_count !== 5'd1) begin
            errors++; $display("[TB] FAIL mid_pre got occ=%0d pkt=%0d want 9/1", occupancy, pkt_count);
        end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || occupancy !== 5'd0 || pkt_count !== 5'd0 || m_if.tdata !== 64'h0 || s_if.tready !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_async got v=%0b occ=%0d pkt=%0d d=%h rdy=%0b want 0/0/0/0/0", m_if.tvalid, occupancy, pkt_count, m_if.tdata, s_if.tready);
        end
        tick();
        aresetn = 1'b1;
        tick();
        s_if.tvalid = 1'b1;
        s_if.tdata  = 64'h5555_AAAA_5555_AAAA;
        s_if.tlast  = 1'b1;
        m_if.tready = 1'b1;
        checks++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
            errors++; $display("[TB] FAIL post_reset_idle got v=%0b rdy=%0b want 0/1", m_if.tvalid, s_if.tready);
        end
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 64'h5555_AAAA_5555_AAAA || m_if.tlast !== 1'b1 || occupancy !== 5'd1) begin
            errors++; $display("[TB] FAIL post_reset_beat got v=%0b d=%h l=%0b occ=%0d want 1/5555aaaa5555aaaa/1/1", m_if.tvalid, m_if.tdata, m_if.tlast, occupancy);
        end
        tick();
        m_if.tready = 1'b0;
        checks++;
        if (m_if.tvalid !== 1'b0 || occupancy !== 5'd0 || pkt_count !== 5'd0) begin
            errors++; $display("[TB] FAIL post_reset_end got v=%0b occ=%0d pkt=%0d want 0/0/0", m_if.tvalid, occupancy, pkt_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_beat();
        test_fill_full();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_stream_fifo.md
Name: axis_stream_fifo

Overview:
Synchronous first-word-fall-through (FWFT) FIFO for 64-bit AXI-Stream beats.
- Sits directly upstream of the compression-engine AXIS slave port.
- Absorbs producer burstiness and decouples producer backpressure from engine backpressure.
- Reports occupancy, almost-full and stored-packet count for flow control and debug.

Parameters:
- DATA_W, 64, tdata width in bits.
- DEPTH, 16, number of beat entries; power of two, minimum 2.
- AFULL_THRESH, DEPTH-2, occupancy at or above which almost_full asserts; valid range 1..DEPTH.

Ports:
- aclk  input  1  single clock; all logic on its rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  FIFO can accept a beat.
- s_tlast  input  1  upstream end of packet.
- s_tdata  input  DATA_W  upstream beat data.
- m_tvalid  output  1  head beat available.
- m_tready  input  1  downstream accepts the head beat.
- m_tlast  output  1  head beat end of packet.
- m_tdata  output  DATA_W  head beat data.
- occupancy  output  $clog2(DEPTH+1)  number of stored beats, 0..DEPTH.
- pkt_count  output  $clog2(DEPTH+1)  number of stored beats with tlast=1.
- almost_full  output  1  occupancy >= AFULL_THRESH.

Behaviour:
- Reset (aresetn low, asynchronous):
  - write pointer, read pointer, occupancy and pkt_count clear to 0.
  - s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, almost_full=0.
  - Storage array is not reset.
- s_tready is registered: 0 during reset, 1 on the first clock edge after reset deasserts, thereafter equal to (occupancy != DEPTH), i.e. not full.
- Write: occurs on s_tvalid && s_tready. {s_tlast, s_tdata} is stored at the write pointer; the write pointer increments and wraps modulo DEPTH.
- Read: occurs on m_tvalid && m_tready. The read pointer increments and wraps modulo DEPTH.
- FWFT output:
  - m_tvalid = (occupancy != 0).
  - m_tdata and m_tlast present the entry at the read pointer.
  - When empty, m_tdata and m_tlast are forced to 0.
- Latency: a beat written at edge N is visible on m_* after edge N. Minimum latency is 1 cycle; there is no combinational input-to-output bypass.
- Occupancy update per edge:
  - write only: +1.
  - read only: -1.
  - both: unchanged.
- pkt_count update per edge:
  - +1 on a write with s_tlast=1.
  - -1 on a read with m_tlast=1.
  - both in the same cycle: unchanged.
- Full, with m_tready=1: s_tready stays 0 that cycle (no write-through-on-read). The read proceeds, and s_tready rises the next cycle.
- Empty, with s_tvalid=1: the write proceeds. m_tvalid stays 0 that cycle and rises next cycle.
- No overflow or underflow is possible; handshake gating prevents both.
- Protocol hold rules:
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast are held stable.
  - m_tvalid never deasserts without a read.
- almost_full is registered, derived from the next-state occupancy, so it is exact in the same cycle as occupancy.
- Reset mid-packet: all stored beats are discarded and pkt_count returns to 0. No partial packet is emitted after reset.
- Pointers are $clog2(DEPTH) bits. Full/empty decisions use occupancy, not pointer comparison.

Decomposition:
- Package axis_pkg holds:
  - localparam AXIS_DATA_W = 64.
  - typedef struct packed {logic tlast; logic [AXIS_DATA_W-1:0] tdata;} axis_beat_t.
  - a function returning the occupancy counter width for a given depth.
- Sub-module axis_fifo_ram:
  - DEPTH x axis_beat_t storage array.
  - Synchronous write port, asynchronous read port.
  - Instantiated once.
- Pointer, occupancy and handshake logic stay in axis_stream_fifo.

Test Plan:
- Reset then idle -> s_tready=0 while aresetn low and 1 one cycle after release; m_tvalid=0, occupancy=0, pkt_count=0, m_tdata=0.
- Single beat: tdata=64'hDEAD_BEEF_0123_4567, tlast=1, m_tready=1 -> m_tvalid rises the next cycle with identical data and tlast=1; pkt_count goes 0->1->0; occupancy goes 0->1->0.
- Fill 16 beats with m_tready=0 -> s_tready=0 after the 16th write; occupancy=16; almost_full asserted from occupancy 14. Then pulse m_tready for one cycle -> s_tready=0 in that cycle and 1 the next; occupancy=15.
- Continuous streaming with s_tvalid=1 and m_tready=1 for 100 beats, data equal to the beat index, tlast every 5th beat -> output sequence 0..99 in order; occupancy steady at 1; pkt_count never exceeds 1.
- Random backpressure (m_tready 50%) with 3 packets of lengths 1, 7 and 20 and pointer wrap-around -> scoreboard match on every beat; tdata stable while stalled; pkt_count equals the number of tlast beats stored at every cycle.
- Assert aresetn low with 9 beats stored mid-packet -> same-cycle (asynchronous) m_tvalid=0, occupancy=0, pkt_count=0. After release, a new single-beat packet emerges with no stale data.
